// File: rtl/bch_keyeq_if.sv
// Handshake bundle between the syndrome stage, the key-equation stage and the Chien search.
// With BCH_KEYEQ_ERRCNT_EN defined the bundle also carries the 2-bit error count.
interface bch_keyeq_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  syn1;
  logic [3:0]  syn3;
  logic [14:0] received_in;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  locator0;
  logic [3:0]  locator1;
  logic [3:0]  locator2;
  logic [14:0] received_out;
  logic        uncorrectable;
`ifdef BCH_KEYEQ_ERRCNT_EN
  logic [1:0]  num_err;

  modport slave (
    input  in_valid, syn1, syn3, received_in, out_ready,
    output in_ready, out_valid, locator0, locator1, locator2, received_out, uncorrectable,
    output num_err
  );

  modport master (
    output in_valid, syn1, syn3, received_in, out_ready,
    input  in_ready, out_valid, locator0, locator1, locator2, received_out, uncorrectable,
    input  num_err
  );
`else
  modport slave (
    input  in_valid, syn1, syn3, received_in, out_ready,
    output in_ready, out_valid, locator0, locator1, locator2, received_out, uncorrectable
  );

  modport master (
    output in_valid, syn1, syn3, received_in, out_ready,
    input  in_ready, out_valid, locator0, locator1, locator2, received_out, uncorrectable
  );
`endif
endinterface

// File: rtl/bch_keyeq.sv
// BCH(15,7) key-equation stage over GF(16) (x^4+x+1): scaled error locator from S1/S3.
// Optional macro BCH_KEYEQ_ERRCNT_EN adds the registered num_err output.
module bch_keyeq (
  input  logic        clk,
  input  logic        rst,
  bch_keyeq_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StMul1, StMul2, StDone} state_e;

  state_e      state_q;
  logic [3:0]  s1_q;
  logic [3:0]  s3_q;
  logic [3:0]  sq_q;
  logic [14:0] recv_q;

  logic        out_valid_q;
  logic [3:0]  loc0_q;
  logic [3:0]  loc1_q;
  logic [3:0]  loc2_q;
  logic [14:0] recv_out_q;
  logic        uncorr_q;

  logic [3:0]  mul_a;
  logic [3:0]  cube;
  logic [3:0]  loc0_d;
  logic [3:0]  loc1_d;
  logic [3:0]  loc2_d;
  logic        uncorr_d;
  logic [1:0]  num_err_d;

  // Horner multiply, MSB of b first, reducing by x^4 = x + 1 on each shift.
  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    p = 4'b0000;
    for (int i = 3; i >= 0; i--) begin
      p = {p[2:0], 1'b0} ^ (p[3] ? 4'b0011 : 4'b0000);
      if (b[i]) p = p ^ a;
    end
    return p;
  endfunction

  // The single shared multiplier: S1*S1 in MUL1, sq*S1 in MUL2.
  always_comb begin
    mul_a = (state_q == StMul2) ? sq_q : s1_q;
    cube  = gf_mul(mul_a, s1_q);
  end

  always_comb begin
    loc0_d    = 4'b0001;
    loc1_d    = 4'b0000;
    loc2_d    = 4'b0000;
    uncorr_d  = 1'b0;
    num_err_d = 2'd0;
    if (s1_q == 4'b0000) begin
      uncorr_d  = (s3_q != 4'b0000);
      num_err_d = uncorr_d ? 2'd3 : 2'd0;
    end else begin
      loc0_d    = s1_q;
      loc1_d    = sq_q;
      loc2_d    = s3_q ^ cube;
      num_err_d = (loc2_d == 4'b0000) ? 2'd1 : 2'd2;
    end
  end

`ifdef BCH_KEYEQ_ERRCNT_EN
  logic [1:0] num_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      num_err_q <= 2'd0;
    end else if (state_q == StMul2) begin
      num_err_q <= num_err_d;
    end
  end

  assign bus.num_err = num_err_q;
`else
  logic unused_num_err;
  assign unused_num_err = ^num_err_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      s1_q        <= 4'b0000;
      s3_q        <= 4'b0000;
      sq_q        <= 4'b0000;
      recv_q      <= 15'd0;
      out_valid_q <= 1'b0;
      loc0_q      <= 4'b0000;
      loc1_q      <= 4'b0000;
      loc2_q      <= 4'b0000;
      recv_out_q  <= 15'd0;
      uncorr_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            s1_q    <= bus.syn1;
            s3_q    <= bus.syn3;
            recv_q  <= bus.received_in;
            state_q <= StMul1;
          end
        end
        StMul1: begin
          sq_q    <= cube;
          state_q <= StMul2;
        end
        StMul2: begin
          loc0_q      <= loc0_d;
          loc1_q      <= loc1_d;
          loc2_q      <= loc2_d;
          uncorr_q    <= uncorr_d;
          recv_out_q  <= recv_q;
          out_valid_q <= 1'b1;
          state_q     <= StDone;
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready      = (state_q == StIdle) && !rst;
  assign bus.out_valid     = out_valid_q;
  assign bus.locator0      = loc0_q;
  assign bus.locator1      = loc1_q;
  assign bus.locator2      = loc2_q;
  assign bus.received_out  = recv_out_q;
  assign bus.uncorrectable = uncorr_q;

endmodule
